// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcode/funct enums, the decoded bundle struct
// and small helpers used by the decoder and the decode stage.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD    = 7'b0000011,
    OP_REG_IMM = 7'b0010011,
    OP_STORE   = 7'b0100011,
    OP_REG_REG = 7'b0110011,
    OP_BRANCH  = 7'b1100011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_t;

  typedef enum logic [6:0] {
    F7_BASE = 7'b0000000,
    F7_ALT  = 7'b0100000
  } funct7_t;

  // Only bit 30 may be set in a legal funct7.
  localparam logic [6:0]  F7_LEGAL_MASK = 7'b0100000;
  localparam logic [31:0] NOP           = 32'h00000013;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alu_alt;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } decoded_instr_t;

  function automatic logic f7_legal(input logic [6:0] f7);
    return (f7 & ~F7_LEGAL_MASK) == 7'b0;
  endfunction

endpackage

// File: rtl/riscv_instr_decode.sv
// Purely combinational RV32I decoder: raw instruction word in,
// register indices, sign-extended immediate and control bits out.
module riscv_instr_decode
  import riscv_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;

  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    dec        = '0;
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.funct3 = f3;

    case (instr[6:0])
      OP_REG_REG: begin
        dec.reg_write = 1'b1;
        dec.alu_alt   = instr[30] && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA);
        dec.illegal   = !f7_legal(f7) ||
                        (f7 == F7_ALT && f3 != F3_ADD_SUB && f3 != F3_SRL_SRA);
      end
      OP_REG_IMM: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_alt   = instr[30] && (f3 == F3_SRL_SRA);
        dec.illegal   = (f3 == F3_SLL && f7 != F7_BASE) ||
                        (f3 == F3_SRL_SRA && !f7_legal(f7));
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
        dec.illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec.rd        = '0;
        dec.mem_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_s;
        dec.illegal   = f3 > 3'b010;
      end
      OP_BRANCH: begin
        dec.rd      = '0;
        dec.branch  = 1'b1;
        dec.imm     = imm_b;
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal words still travel downstream but must not change architectural state.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
    end
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode pipeline stage: valid/ready register between fetch and execute,
// with flush from branch resolution and a saturating illegal-instruction count.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_alu_alt,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_use_imm,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  decoded_instr_t dec;
  decoded_instr_t bundle;
  logic [XLEN-1:0] pc_q;
  logic            accept;

  riscv_instr_decode u_decode (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the bundle is a handful of flops, not a memory, so all of it is reset and execute never sees X.
    if (rst) begin
      out_valid     <= 1'b0;
      bundle        <= '0;
      pc_q          <= '0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      out_valid <= 1'b1;
      bundle    <= dec;
      pc_q      <= in_pc;
      if (dec.illegal && illegal_count != '1)
        illegal_count <= illegal_count + CNT_W'(1);
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc        = pc_q;
  assign out_rd        = bundle.rd;
  assign out_rs1       = bundle.rs1;
  assign out_rs2       = bundle.rs2;
  assign out_funct3    = bundle.funct3;
  assign out_alu_alt   = bundle.alu_alt;
  assign out_imm       = XLEN'($signed(bundle.imm));
  assign out_use_imm   = bundle.use_imm;
  assign out_reg_write = bundle.reg_write;
  assign out_mem_read  = bundle.mem_read;
  assign out_mem_write = bundle.mem_write;
  assign out_branch    = bundle.branch;
  assign out_illegal   = bundle.illegal;

endmodule
